// File: rtl/inst_sram_resp_pkg.sv
// -----------------------------------------------------------------------------
// inst_sram_resp_pkg
// Shared definitions for the SRAM-like bus responder:
//   - bus access-size encodings (SIZE_BYTE / SIZE_HALF / SIZE_WORD)
//   - width of the outstanding-transaction counter (covers MAX_OUT up to 4)
//   - tap mask and feedback helper for the 16-bit Fibonacci delay LFSR
//     (taps 16, 14, 13, 11 -> state bits 15, 13, 12, 10)
// -----------------------------------------------------------------------------
package inst_sram_resp_pkg;

    localparam logic [1:0]  SIZE_BYTE = 2'd0;
    localparam logic [1:0]  SIZE_HALF = 2'd1;
    localparam logic [1:0]  SIZE_WORD = 2'd2;

    // Outstanding counter holds 0..MAX_OUT with MAX_OUT in 1..4.
    localparam int unsigned CNT_W     = 3;

    // Bits 15, 13, 12 and 10 of the state feed the XOR.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Feedback bit shifted into lfsr[0] on every advance.
    function automatic logic lfsr_feedback(input logic [15:0] state);
        return ^(state & LFSR_TAPS);
    endfunction

endpackage

// File: rtl/inst_sram_resp_fifo.sv
// -----------------------------------------------------------------------------
// resp_fifo
// Small synchronous FIFO holding responses that could not be delivered in the
// cycle the RAM produced them. Push and pop may happen in the same cycle.
// A push into a full FIFO is ignored unless a pop frees a slot that cycle.
//
// Parameters: DEPTH (entries, >= 1), WIDTH (bits per entry)
// Ports:
//   clk, resetn  : clock, asynchronous active-low reset (FIFO becomes empty)
//   push, din    : write strobe and data
//   pop          : read strobe (ignored when empty)
//   dout         : head entry (meaningful when !empty)
//   empty, full  : occupancy flags
// -----------------------------------------------------------------------------
module resp_fifo
    import inst_sram_resp_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int unsigned      PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned      FILL_W    = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(DEPTH);

    logic [WIDTH-1:0]  mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [FILL_W-1:0] fill_r;
    logic              push_ok_s;
    logic              pop_ok_s;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        if (p == PTR_LAST) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    assign empty     = (fill_r == {FILL_W{1'b0}});
    assign full      = (fill_r == FILL_MAX);
    assign pop_ok_s  = pop & ~empty;
    assign push_ok_s = push & (~full | pop_ok_s);
    assign dout      = mem_r[rd_ptr_r];

    // Storage, pointers and fill level.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            fill_r   <= {FILL_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= next_ptr(wr_ptr_r);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= next_ptr(rd_ptr_r);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   fill_r <= fill_r + FILL_W'(1);
                2'b01:   fill_r <= fill_r - FILL_W'(1);
                default: fill_r <= fill_r;
            endcase
        end
    end

endmodule

// File: rtl/inst_sram_resp.sv
// -----------------------------------------------------------------------------
// inst_sram_resp
// Responder end of the SRAM-like fetch/data bus. Accepts req/addr_ok address
// handshakes, drives a single-port synchronous RAM (1-cycle read latency) in
// the accept cycle, and returns in-order data_ok responses. Up to MAX_OUT
// transactions may be accepted but not yet answered.
//
// Optional feature macro: RANDOM_DELAY_EN
//   When defined, a 16-bit Fibonacci LFSR randomly throttles accepts and
//   responses to stress master stall logic. When undefined both gates are
//   tied high and latency is a fixed one cycle.
//
// Parameters: MEM_AW (RAM word-address width), MAX_OUT (1..4),
//             LFSR_SEED (LFSR reset value, used with RANDOM_DELAY_EN only)
// Ports:
//   clk, resetn                        : clock, asynchronous active-low reset
//   req, wr, size, wstrb, addr, wdata  : master request
//   addr_ok                            : request accepted this cycle
//   data_ok, rdata                     : response (rdata is 0 without data_ok)
//   ram_en, ram_we, ram_addr, ram_wdata: RAM command (all 0 when idle)
//   ram_rdata                          : RAM read data, cycle after a read
// -----------------------------------------------------------------------------
module inst_sram_resp
    import inst_sram_resp_pkg::*;
#(
    parameter int unsigned MEM_AW    = 14,
    parameter int unsigned MAX_OUT   = 2,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req,
    input  logic              wr,
    input  logic [1:0]        size,
    input  logic [3:0]        wstrb,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              addr_ok,
    output logic              data_ok,
    output logic [31:0]       rdata,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [MEM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUT);

    logic [CNT_W-1:0] cnt_r;
    logic             inflight_r;
    logic             inflight_wr_r;
    logic             acc_gate_s;
    logic             rsp_gate_s;
    logic [31:0]      payload_s;
    logic             fifo_push_s;
    logic             fifo_pop_s;
    logic [31:0]      fifo_head_s;
    logic             fifo_empty_s;
    logic             fifo_full_s;
    logic             unused_s;

`ifdef RANDOM_DELAY_EN
    logic [15:0] lfsr_r;

    // Free-running delay LFSR, advances every cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lfsr_r <= LFSR_SEED;
        end else begin
            lfsr_r <= {lfsr_r[14:0], lfsr_feedback(lfsr_r)};
        end
    end

    assign acc_gate_s = ~lfsr_r[0] | lfsr_r[3];
    assign rsp_gate_s = ~lfsr_r[1] | lfsr_r[5];
    assign unused_s   = ^{size, addr[31:MEM_AW+2], addr[1:0], fifo_full_s};
`else
    assign acc_gate_s = 1'b1;
    assign rsp_gate_s = 1'b1;
    assign unused_s   = ^{size, addr[31:MEM_AW+2], addr[1:0], fifo_full_s, LFSR_SEED};
`endif

    // Accept decision and RAM command; uses registered cnt only, so the
    // response path never feeds back into addr_ok within a cycle.
    always_comb begin
        addr_ok   = req & (cnt_r < CNT_MAX) & acc_gate_s;
        ram_en    = 1'b0;
        ram_we    = 4'b0000;
        ram_addr  = {MEM_AW{1'b0}};
        ram_wdata = 32'h0000_0000;
        if (addr_ok) begin
            ram_en    = 1'b1;
            ram_we    = wr ? wstrb : 4'b0000;
            ram_addr  = addr[MEM_AW+1:2];
            ram_wdata = wdata;
        end else begin
            ram_en    = 1'b0;
        end
    end

    // Outstanding-transaction counter: accept and response in one cycle cancel.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            case ({addr_ok, data_ok})
                2'b10:   cnt_r <= cnt_r + CNT_W'(1);
                2'b01:   cnt_r <= cnt_r - CNT_W'(1);
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    // Marks the cycle in which the RAM result of the previous accept is valid.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            inflight_r    <= 1'b0;
            inflight_wr_r <= 1'b0;
        end else begin
            inflight_r    <= addr_ok;
            inflight_wr_r <= addr_ok & wr;
        end
    end

    // Writes still answer once, with a zero payload.
    assign payload_s = inflight_wr_r ? 32'h0000_0000 : ram_rdata;

    resp_fifo #(
        .DEPTH (MAX_OUT),
        .WIDTH (32)
    ) u_resp_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (fifo_push_s),
        .din    (payload_s),
        .pop    (fifo_pop_s),
        .dout   (fifo_head_s),
        .empty  (fifo_empty_s),
        .full   (fifo_full_s)
    );

    // Response select: buffered head first, otherwise bypass the fresh RAM
    // result; anything not delivered this cycle is queued behind older entries.
    always_comb begin
        data_ok     = 1'b0;
        rdata       = 32'h0000_0000;
        fifo_push_s = 1'b0;
        fifo_pop_s  = 1'b0;
        if (!fifo_empty_s) begin
            data_ok     = rsp_gate_s;
            rdata       = rsp_gate_s ? fifo_head_s : 32'h0000_0000;
            fifo_pop_s  = rsp_gate_s;
            fifo_push_s = inflight_r;
        end else if (inflight_r) begin
            data_ok     = rsp_gate_s;
            rdata       = rsp_gate_s ? payload_s : 32'h0000_0000;
            fifo_push_s = ~rsp_gate_s;
        end else begin
            data_ok     = 1'b0;
        end
    end

endmodule

// File: tb/tb_inst_sram_resp.sv
// -----------------------------------------------------------------------------
// tb_inst_sram_resp
// Directed bench for inst_sram_resp with a behavioural byte-enabled RAM.
// The driver pushes the expected response of every accepted request into a
// queue; an independent monitor pops and compares on every data_ok.
// -----------------------------------------------------------------------------
module tb_inst_sram_resp;

    localparam int unsigned MEM_AW  = 14;
    localparam int unsigned MAX_OUT = 2;

    logic              clk;
    logic              resetn;
    logic              req;
    logic              wr;
    logic [1:0]        size;
    logic [3:0]        wstrb;
    logic [31:0]       addr;
    logic [31:0]       wdata;
    logic              addr_ok;
    logic              data_ok;
    logic [31:0]       rdata;
    logic              ram_en;
    logic [3:0]        ram_we;
    logic [MEM_AW-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic [31:0] mem [1 << MEM_AW];
    bit          mem_init = 1'b0;

    inst_sram_resp #(
        .MEM_AW    (MEM_AW),
        .MAX_OUT   (MAX_OUT),
        .LFSR_SEED (16'hACE1)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .req       (req),
        .wr        (wr),
        .size      (size),
        .wstrb     (wstrb),
        .addr      (addr),
        .wdata     (wdata),
        .addr_ok   (addr_ok),
        .data_ok   (data_ok),
        .rdata     (rdata),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Initial RAM image.
    function automatic logic [31:0] init_word(input int w);
        if (w == 0)                  return 32'h0280_0000;
        else if (w == 4)             return 32'h1122_3344;
        else if (w >= 32'h40 && w < 32'h48) return 32'hA000_0000 | 32'(w);
        else if (w >= 32'h80 && w < 32'hA0) return 32'hC0DE_0000 | 32'(w);
        else                         return 32'h0000_0000;
    endfunction

    // Behavioural single-port RAM, one-cycle read latency, read-first.
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int w = 0; w < 256; w++) mem[w] <= init_word(w);
            mem_init <= 1'b1;
        end else if (ram_en) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
            if (ram_we == 4'b0000) ram_rdata <= mem[ram_addr];
        end
    end

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor: every response must match the oldest accepted request.
    always @(negedge clk) begin
        if (resetn === 1'b1 && data_ok === 1'b1) begin
            check("data_ok_has_accept", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("rdata", rdata, mon_e.data);
`ifndef RANDOM_DELAY_EN
                check("latency", 32'(cyc - mon_e.cyc), 32'd1);
`endif
            end
        end
    end

    // Present one request, wait (bounded) for addr_ok, check the RAM command
    // and push the expected response. Returns at posedge+1 with req low.
    task automatic issue(input logic w, input logic [3:0] strb, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] exp, output int acc_cyc);
        bit          got;
        logic [31:0] ea;
        exp_t        e;
        got     = 1'b0;
        acc_cyc = -1;
        ea      = 32'(a[MEM_AW+1:2]);
        req     = 1'b1;
        wr      = w;
        size    = 2'd2;
        wstrb   = strb;
        addr    = a;
        wdata   = d;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            if (addr_ok) begin
                got     = 1'b1;
                acc_cyc = cyc;
                check("ram_en", 32'(ram_en), 32'd1);
                check("ram_we", 32'(ram_we), w ? 32'(strb) : 32'd0);
                check("ram_addr", 32'(ram_addr), ea);
                check("ram_wdata", ram_wdata, d);
                e.data = exp;
                e.cyc  = cyc;
                exp_q.push_back(e);
                check("outstanding_bound", 32'(exp_q.size() <= int'(MAX_OUT)), 32'd1);
            end
            @(posedge clk);
            #1;
        end
        if (!got) check("addr_ok_timeout", 32'd0, 32'd1);
        req = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 100 && exp_q.size() != 0; k++) begin
            @(posedge clk);
            #1;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int ac;
        int first;
        resetn = 1'b0;
        req    = 1'b0;
        wr     = 1'b0;
        size   = 2'd0;
        wstrb  = 4'b0000;
        addr   = 32'h0;
        wdata  = 32'h0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;

        // Idle after reset: everything quiet.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle_addr_ok", 32'(addr_ok), 32'd0);
            check("idle_data_ok", 32'(data_ok), 32'd0);
            check("idle_ram_en", 32'(ram_en), 32'd0);
            check("idle_rdata", rdata, 32'd0);
        end
        @(posedge clk);
        #1;

        // Boot-vector read.
        issue(1'b0, 4'b0000, 32'h1C00_0000, 32'h0, 32'h0280_0000, ac);
        idle(2);

        // Partial write then read-back of the merged word.
        issue(1'b1, 4'b0011, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, ac);
        issue(1'b0, 4'b0000, 32'h0000_0010, 32'h0, 32'h1122_BEEF, ac);
        idle(2);

        // Eight back-to-back reads with req held high.
        first = 0;
        for (int i = 0; i < 8; i++) begin
            issue(1'b0, 4'b0000, 32'h100 + 32'(4 * i), 32'h0, 32'hA000_0040 | 32'(i), ac);
            if (i == 0) first = ac;
`ifndef RANDOM_DELAY_EN
            else check("b2b_accept_cycle", 32'(ac - first), 32'(i));
`endif
        end
        wait_drain();

`ifdef RANDOM_DELAY_EN
        // Throttled random reads.
        for (int i = 0; i < 200; i++) begin
            int r;
            r = int'($urandom_range(0, 31));
            issue(1'b0, 4'b0000, 32'((32'h80 + r) << 2), 32'h0, 32'hC0DE_0080 | 32'(r), ac);
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        wait_drain();
`endif

        // Reset with transactions in flight: their responses must vanish.
        issue(1'b0, 4'b0000, 32'h0000_0104, 32'h0, 32'hA000_0041, ac);
        issue(1'b0, 4'b0000, 32'h0000_0108, 32'h0, 32'hA000_0042, ac);
        resetn = 1'b0;
        exp_q.delete();
        idle(2);
        resetn = 1'b1;
        idle(5);

        // Fresh accesses after reset; RAM content survives.
        issue(1'b0, 4'b0000, 32'h1C00_0000, 32'h0, 32'h0280_0000, ac);
        issue(1'b0, 4'b0000, 32'h0000_0010, 32'h0, 32'h1122_BEEF, ac);
        wait_drain();
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
